// File: rtl/toggle_event_gen_pkg.sv
// Shared definitions for the toggle coverage front end: FSM states and the
// encoding of per-signal cover points into the sink's valid vector.
package toggle_event_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam int unsigned RISE_OFS       = 0;
  localparam int unsigned FALL_OFS       = 1;
  localparam int unsigned POINTS_PER_SIG = 2;

endpackage

// File: rtl/toggle_event_gen_popcount.sv
// Combinational population count of an N-bit vector.
module toggle_popcount #(
  parameter int unsigned N  = 130,
  parameter int unsigned CW = 8
) (
  input  logic [N-1:0]  vec,
  output logic [CW-1:0] count_c
);

  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      count_c = count_c + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/toggle_event_gen.sv
// Per-bit rise/fall detector feeding the toggle-coverage sink, with a sticky
// covered mask, per-cycle first-hit count and running covered total.
module toggle_event_gen
  import toggle_event_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 65,
  parameter bit          ONCE  = 1'b1,
  localparam int unsigned CW   = $clog2(2*WIDTH+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     sample,
  input  logic                 enable,
  input  logic                 clear,
  output logic [2*WIDTH-1:0]   valid,
  output logic [CW-1:0]        new_count,
  output logic [CW-1:0]        covered_total,
  output logic                 all_covered
);

  localparam int unsigned NP = POINTS_PER_SIG * WIDTH;

  state_e          state, state_nxt;
  logic [WIDTH-1:0] prev_q;
  logic [NP-1:0]   hit_c, hit_q, fresh_c, mask_q, valid_q;
  logic [CW-1:0]   fresh_cnt_c, new_q, total_q;

  // Next-state: prime one cycle so prev_q holds live history before detecting
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = PRIME;
      PRIME:   state_nxt = ACTIVE;
      ACTIVE:  state_nxt = ACTIVE;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  // Interleaved rise/fall detection, only against history taken in PRIME/ACTIVE
  always_comb begin
    hit_c = '0;
    if (state == ACTIVE) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        hit_c[POINTS_PER_SIG*i + RISE_OFS] = ~prev_q[i] &  sample[i];
        hit_c[POINTS_PER_SIG*i + FALL_OFS] =  prev_q[i] & ~sample[i];
      end
    end
  end

  assign fresh_c = hit_q & ~mask_q;

  toggle_popcount #(
    .N  (NP),
    .CW (CW)
  ) u_popcount (
    .vec     (fresh_c),
    .count_c (fresh_cnt_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      prev_q  <= '0;
      hit_q   <= '0;
      mask_q  <= '0;
      valid_q <= '0;
      new_q   <= '0;
      total_q <= '0;
    end else begin
      state <= state_nxt;
      if (state != IDLE) prev_q <= sample;
      // clear also drops the hit in flight so a colliding toggle is discarded
      if (clear) begin
        hit_q   <= '0;
        mask_q  <= '0;
        valid_q <= '0;
        new_q   <= '0;
        total_q <= '0;
      end else if (!enable) begin
        hit_q   <= '0;
        valid_q <= '0;
        new_q   <= '0;
      end else begin
        hit_q   <= hit_c;
        mask_q  <= mask_q | hit_q;
        valid_q <= ONCE ? fresh_c : hit_q;
        new_q   <= fresh_cnt_c;
        total_q <= total_q + fresh_cnt_c;
      end
    end
  end

  assign valid         = valid_q;
  assign new_count     = new_q;
  assign covered_total = total_q;
  assign all_covered   = (total_q == CW'(NP));

endmodule

// File: tb/tb_toggle_event_gen.sv
// Directed bench for toggle_event_gen: table of per-cycle vectors plus
// hand sequences for full coverage and asynchronous reset.
module tb_toggle_event_gen;

  localparam int unsigned W  = 65;
  localparam int unsigned NP = 2*W;
  localparam int unsigned CW = 8;

  logic              clock, reset, enable, clear;
  logic [W-1:0]      sample;
  logic [NP-1:0]     valid1, valid0;
  logic [CW-1:0]     new1, new0, tot1, tot0;
  logic              allc1, allc0;

  int vectors = 0;
  int miscompares = 0;

  toggle_event_gen #(.WIDTH(W), .ONCE(1'b1)) dut_once (
    .clock(clock), .reset(reset), .sample(sample), .enable(enable), .clear(clear),
    .valid(valid1), .new_count(new1), .covered_total(tot1), .all_covered(allc1)
  );

  toggle_event_gen #(.WIDTH(W), .ONCE(1'b0)) dut_all (
    .clock(clock), .reset(reset), .sample(sample), .enable(enable), .clear(clear),
    .valid(valid0), .new_count(new0), .covered_total(tot0), .all_covered(allc0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          en;
    logic          clr;
    logic [W-1:0]  samp;
    logic [NP-1:0] ev1;
    logic [NP-1:0] ev0;
    logic [CW-1:0] enew;
    logic [CW-1:0] etot;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic clr, input logic [W-1:0] samp,
                              input logic [NP-1:0] ev1, input logic [NP-1:0] ev0,
                              input logic [CW-1:0] enew, input logic [CW-1:0] etot);
    vec_t v;
    v.en = en; v.clr = clr; v.samp = samp;
    v.ev1 = ev1; v.ev0 = ev0; v.enew = enew; v.etot = etot;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [W-1:0]  s0, sb0, sb05, s_all;
  logic [NP-1:0] rise_all, fall_all;

  initial begin
    s0 = '0; sb0 = W'(1); sb05 = W'(33); s_all = '1;
    rise_all = '0; fall_all = '0;
    for (int i = 0; i < int'(W); i++) begin
      rise_all[2*i]   = 1'b1;
      fall_all[2*i+1] = 1'b1;
    end

    for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 0, s0, '0, '0, 0, 0));
    tbl.push_back(mk(1, 0, sb0,  '0,        '0,        0, 0));
    tbl.push_back(mk(1, 0, sb0,  NP'(1),    NP'(1),    1, 1));
    tbl.push_back(mk(1, 0, s0,   '0,        '0,        0, 1));
    tbl.push_back(mk(1, 0, sb0,  NP'(2),    NP'(2),    1, 2));
    tbl.push_back(mk(1, 0, sb0,  '0,        NP'(1),    0, 2));
    tbl.push_back(mk(1, 0, sb0,  '0,        '0,        0, 2));
    tbl.push_back(mk(1, 1, sb05, '0,        '0,        0, 0));
    tbl.push_back(mk(1, 0, sb05, '0,        '0,        0, 0));
    tbl.push_back(mk(1, 0, sb0,  '0,        '0,        0, 0));
    tbl.push_back(mk(1, 0, sb0,  NP'(2048), NP'(2048), 1, 1));
    tbl.push_back(mk(1, 0, sb05, '0,        '0,        0, 1));
    tbl.push_back(mk(1, 0, sb05, NP'(1024), NP'(1024), 1, 2));

    reset = 1'b0; enable = 1'b0; clear = 1'b0; sample = '0;
    #12;
    chk("reset_valid", valid1, '0);
    chk("reset_new", new1, '0);
    chk("reset_total", tot1, '0);
    chk("reset_allc", allc1, '0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      enable = tbl[i].en; clear = tbl[i].clr; sample = tbl[i].samp;
      step();
      chk($sformatf("v%0d_valid_once", i), valid1, tbl[i].ev1);
      chk($sformatf("v%0d_valid_all", i), valid0, tbl[i].ev0);
      chk($sformatf("v%0d_new", i), new1, tbl[i].enew);
      chk($sformatf("v%0d_new_all", i), new0, tbl[i].enew);
      chk($sformatf("v%0d_total", i), tot1, tbl[i].etot);
      chk($sformatf("v%0d_allc", i), allc1, 1'b0);
    end

    // full coverage: clear (discarding falls of bits 0,5), rise all, fall all
    clear = 1'b1; sample = s0; step();
    chk("full_clr_total", tot1, '0);
    clear = 1'b0; sample = s_all; step();
    chk("full_rise_wait", valid1, '0);
    step();
    chk("full_rise_valid", valid1, rise_all);
    chk("full_rise_valid_all", valid0, rise_all);
    chk("full_rise_new", new1, 65);
    chk("full_rise_total", tot1, 65);
    chk("full_rise_allc", allc1, 1'b0);
    sample = s0; step();
    chk("full_fall_wait", valid1, '0);
    step();
    chk("full_fall_valid", valid1, fall_all);
    chk("full_fall_new", new1, 65);
    chk("full_fall_total", tot1, 130);
    chk("full_allc", allc1, 1'b1);
    chk("full_allc_all", allc0, 1'b1);
    step();
    chk("full_hold_valid", valid1, '0);
    chk("full_hold_total", tot1, 130);

    // async reset while the report-every-toggle instance is pulsing
    sample = sb0; step(); step();
    chk("pre_rst_valid_all", valid0, NP'(1));
    chk("pre_rst_valid_once", valid1, '0);
    chk("pre_rst_new", new1, '0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid_all", valid0, '0);
    chk("async_rst_total", tot1, '0);
    chk("async_rst_allc", allc1, 1'b0);
    #1 reset = 1'b1;
    sample = s0;  step(); chk("rel_e1_valid", valid0, '0);
    sample = sb0; step(); chk("rel_e2_valid", valid0, '0);
    sample = s0;  step(); chk("rel_e3_valid", valid0, '0);
    sample = sb0; step();
    chk("rel_e4_valid_all", valid0, NP'(2));
    chk("rel_e4_valid_once", valid1, NP'(2));
    chk("rel_e4_total", tot1, 1);

    // enable drop keeps totals, kills pulses
    step();
    chk("en_pre_valid_all", valid0, NP'(1));
    enable = 1'b0; sample = s0; step();
    chk("en_off_valid_all", valid0, '0);
    chk("en_off_total", tot1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
